// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: instruction-type select codes used by the
// immediate extender, major opcode constants, the sequential fetch step,
// and the fetch-buffer entry layout with its opcode pre-decoder.
package riscv_pkg;

    typedef enum logic [1:0] {
        I_TYPE = 2'd0,
        S_TYPE = 2'd1,
        B_TYPE = 2'd2,
        J_TYPE = 2'd3
    } InstType;

    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OP_STORE   = 7'b0100011;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [31:0] INSTR_STEP = 32'd4;

    // One buffered instruction: word, its PC and its pre-decoded type (66 bits)
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        InstType     itype;
    } FetchEntry;

    // R and U formats carry no immediate the extender cares about, so they
    // share the I code with everything else that is not B, S or J.
    function automatic InstType predecode(input logic [6:0] opcode);
        InstType t;
        case (opcode)
            OP_BRANCH: t = B_TYPE;
            OP_STORE:  t = S_TYPE;
            OP_JAL:    t = J_TYPE;
            default:   t = I_TYPE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with registered storage, occupancy count and
// simultaneous push/pop (including push while full when a pop frees a slot).
// A flush empties it in one cycle and wins over push and pop.
module instr_fifo #(
    parameter int   DEPTH = 2,
    parameter int   WIDTH = 66,
    localparam int  CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Storage, pointers and count; storage is cleared on reset so the head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (doPop) rdPtr_q <= nextPtr(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rdPtr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit of DEPTH (outstanding fetches plus buffered words), buffers returned
// words with their PC and pre-decoded type, and redirects on taken
// branches/jumps, dropping responses to requests issued before the redirect.
// Optional build macro IFETCH_MISALIGN_CHK_EN adds the fetch_misalign trap,
// which halts fetching on a target with bit 1 set until the next redirect.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_imm,
    input  logic        redirect_jalr,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  inst_type
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rspPc_q, rspPc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] dropCnt_q, dropCnt_d;
    logic [CW-1:0] fifoCount;
    logic [CW:0]   slotsUsed;
    logic [31:0]   target;
    logic          fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic          reqFire, halted;
    FetchEntry     pushEntry, headEntry;

    // Redirect target; jalr clears bit 0 before any alignment check
    always_comb begin
        target = redirect_base + redirect_imm;
        if (redirect_jalr) target[0] = 1'b0;
    end

    // A same-cycle pop frees a slot, which is what sustains one fetch per cycle
    assign slotsUsed      = {1'b0, inflight_q} + {1'b0, fifoCount} - {{CW{1'b0}}, fifoPop};
    assign imem_req_valid = !rst && (slotsUsed < (CW + 1)'(DEPTH)) && !redirect_valid && !halted;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc_q;

    assign instr_valid = !fifoEmpty;
    assign fifoPop     = instr_valid && instr_ready;
    assign fifoPush    = imem_rsp_valid && !redirect_valid && (dropCnt_q == '0)
                         && (!fifoFull || fifoPop);
    assign pushEntry   = '{data: imem_rsp_data, pc: rspPc_q, itype: predecode(imem_rsp_data[6:0])};

    // Next PC, outstanding/drop counters and PC of the next word to be kept
    always_comb begin
        pc_d       = pc_q;
        rspPc_d    = rspPc_q;
        inflight_d = inflight_q;
        dropCnt_d  = dropCnt_q;
        if (reqFire) pc_d = pc_q + INSTR_STEP;
        case ({reqFire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (imem_rsp_valid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CW'(1);
        if (fifoPush) rspPc_d = rspPc_q + INSTR_STEP;
        if (redirect_valid) begin
            pc_d      = target;
            rspPc_d   = target;
            dropCnt_d = inflight_q - CW'(imem_rsp_valid);
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rspPc_q    <= RESET_PC;
            inflight_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            rspPc_q    <= rspPc_d;
            inflight_q <= inflight_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // Every redirect re-evaluates the trap, so a good target clears it
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) misalign_d = target[1];
    end

    // Misalignment trap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign halted         = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign halted = 1'b0;
`endif

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(FetchEntry))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (pushEntry),
        .rdata (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign instr     = headEntry.data;
    assign instr_pc  = headEntry.pc;
    assign inst_type = headEntry.itype;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a bench-side instruction memory with
// selectable latency, a scoreboard of expected decode-side words, and a
// linear sequence of directed scenarios (startup, throughput, stall,
// redirects, pre-decode, and the optional misalignment trap).
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        redirect_jalr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  inst_type;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    instr_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
        .redirect_jalr  (redirect_jalr),
`ifdef IFETCH_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .inst_type      (inst_type)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } MemReq;
    typedef struct { logic [31:0] data; logic [31:0] pc; logic [1:0] t; } ExpWord;

    MemReq       memQ[$];
    ExpWord      sb[$];
    logic [1:0]  popTypes[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          memLat = 1;
    int          epoch = 0;
    int          fireCnt = 0;
    int          popCnt = 0;
    int          popBefore;
    logic [31:0] expPc = 32'h100;
    logic [31:0] lastAddr, lastInstrPc, lastPopPc;
    logic        lastReq, lastRsp, lastInstrValid, lastMis;
    logic        halted = 1'b0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [6:0] op;
        case (a)
            32'h500: return 32'h0000_0063;
            32'h504: return 32'h0000_2023;
            32'h508: return 32'h0000_006F;
            32'h50C: return 32'h0000_0013;
            default: ;
        endcase
        case (a[3:2])
            2'd0:    op = 7'h63;
            2'd1:    op = 7'h23;
            2'd2:    op = 7'h6F;
            default: op = 7'h13;
        endcase
        return {a[26:2], op};
    endfunction

    function automatic logic [1:0] refType(input logic [31:0] w);
        case (w[6:0])
            7'b1100011: return 2'd2;
            7'b0100011: return 2'd1;
            7'b1101111: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge: compares DUT outputs against the
    // scoreboard and advances the memory/scoreboard model for this cycle.
    task automatic checkOutput(input logic rdy, input logic redir, input logic [31:0] tgt);
        MemReq m;
        logic [31:0] w;
        check1("occupancy", (memQ.size() + sb.size()) <= DEPTH, 1'b1);
        check1("instr_valid", instr_valid, sb.size() > 0);
        lastReq        = imem_req_valid;
        lastAddr       = imem_addr;
        lastRsp        = imem_rsp_valid;
        lastInstrValid = instr_valid;
        lastInstrPc    = instr_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
        lastMis = fetch_misalign;
        check1("misalign_flag", fetch_misalign, halted);
        if (halted) check1("halted_no_req", imem_req_valid, 1'b0);
`else
        lastMis = 1'b0;
`endif
        if (instr_valid && sb.size() > 0) begin
            check32("instr", instr, sb[0].data);
            check32("instr_pc", instr_pc, sb[0].pc);
            check32("inst_type", 32'(inst_type), 32'(sb[0].t));
            if (rdy) begin
                lastPopPc = instr_pc;
                popTypes.push_back(inst_type);
                popCnt++;
                void'(sb.pop_front());
            end
        end
        if (redir) check1("no_req_in_redirect", imem_req_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            check32("imem_addr", imem_addr, expPc);
            memQ.push_back('{imem_addr, cyc + memLat, epoch});
            expPc = expPc + 32'd4;
            fireCnt++;
        end
        if (imem_rsp_valid && memQ.size() > 0) begin
            m = memQ.pop_front();
            if (m.ep == epoch && !redir) begin
                w = memWord(m.addr);
                sb.push_back('{w, m.addr, refType(w)});
            end
        end
        if (redir) begin
            epoch++;
            sb.delete();
            expPc  = tgt;
            halted = tgt[1];
        end
    endtask

    // Drives one clock cycle of inputs and memory responses
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] base,
                                 input logic [31:0] imm, input logic jalr);
        logic [31:0] tgt;
        tgt = base + imm;
        if (jalr) tgt[0] = 1'b0;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_base  = base;
        redirect_imm   = imm;
        redirect_jalr  = jalr;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        checkOutput(rdy, redir, tgt);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_base  = 32'h0;
        redirect_imm   = 32'h0;
        redirect_jalr  = 1'b0;
        instr_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);
        check32("rst_inst_type", 32'(inst_type), 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        check1("rst_misalign", fetch_misalign, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Startup: consecutive fetches from RESET_PC, first word visible in cycle 2
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("c0_req", lastReq, 1'b1);
        check32("c0_addr", lastAddr, 32'h100);
        check1("c0_valid", lastInstrValid, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check32("c1_addr", lastAddr, 32'h104);
        check1("c1_valid", lastInstrValid, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check32("c2_addr", lastAddr, 32'h108);
        check1("c2_valid", lastInstrValid, 1'b1);
        check32("c2_pc", lastInstrPc, 32'h100);

        // Sustained one fetch and one delivery per cycle
        fireCnt = 0;
        popCnt  = 0;
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check32("throughput_fetch", 32'(fireCnt), 32'd8);
        check32("throughput_pop", 32'(popCnt), 32'd8);

        // Decode stall: buffer fills, requests stop, head held stable
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("stall_valid", lastInstrValid, 1'b1);
        check1("stall_no_req", lastReq, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Redirect with two fetches outstanding
        memLat = 2;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10 && memQ.size() != 2; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("two_inflight_reached", memQ.size() == 2, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'hFFFF_FFF8, 1'b0);
        popBefore = popCnt;
        for (int i = 0; i < 20 && popCnt == popBefore; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("redirect_delivered", popCnt > popBefore, 1'b1);
        check32("redirect_first_pc", lastPopPc, 32'h1F8);

        // jalr redirect with a response landing in the redirect cycle
        memLat = 1;
        repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h301, 32'h0, 1'b1);
        check1("jalr_rsp_in_cycle", lastRsp, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("jalr_req_next", lastReq, 1'b1);
        check32("jalr_addr", lastAddr, 32'h300);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Pre-decode of B, S, J and I words
        applyStimulus(1'b1, 1'b1, 32'h500, 32'h0, 1'b0);
        popTypes.delete();
        for (int i = 0; i < 20 && popTypes.size() < 4; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("types_delivered", popTypes.size() >= 4, 1'b1);
        if (popTypes.size() >= 4) begin
            check32("type_branch", 32'(popTypes[0]), 32'd2);
            check32("type_store", 32'(popTypes[1]), 32'd1);
            check32("type_jal", 32'(popTypes[2]), 32'd3);
            check32("type_other", 32'(popTypes[3]), 32'd0);
        end

`ifdef IFETCH_MISALIGN_CHK_EN
        // Misaligned target traps and halts until a good redirect
        applyStimulus(1'b1, 1'b1, 32'h402, 32'h0, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("misalign_set", lastMis, 1'b1);
        check1("misalign_no_req", lastReq, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h400, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        check1("misalign_cleared", lastMis, 1'b0);
        check1("resume_req", lastReq, 1'b1);
        check32("resume_addr", lastAddr, 32'h400);
`endif

        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC-V core: owns the program counter, issues word fetches to instruction memory, buffers returned words in a small in-order prefetch FIFO and presents them to decode with a valid/ready handshake. It sits directly upstream of the immediate extender: it delivers the instruction word, whose bits [31:7] feed the extender, together with a pre-decoded 2-bit instruction-type code, whose values are the extender's type-select encoding. It also consumes the extended immediate on redirects, forming branch and jump targets.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, prefetch FIFO entries; also the maximum number of outstanding fetches plus buffered words
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request
- imem_addr  out  32  fetch address (current PC)
- imem_rsp_valid  in  1  response word valid; responses return in order, at least 1 cycle after acceptance
- imem_rsp_data  in  32  response instruction word
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_base  in  32  PC of the branch/jal, or rs1 for jalr
- redirect_imm  in  32  sign-extended immediate from the immediate extender
- redirect_jalr  in  1  clear bit 0 of the computed target
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode consumes it
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- inst_type  out  2  pre-decoded type: 0 = I, 1 = S, 2 = B, 3 = J
- fetch_misalign  out  1  misaligned target trap; only present with the macro

## Operation
- Credit rule: issue only when inflight + fifo_count < DEPTH.
- imem_req_valid = !rst && credit available && !redirect_valid && !halted.
- On request acceptance (imem_req_valid && imem_req_ready): PC <= PC + 4 (32-bit wrap) and inflight++.
- On imem_rsp_valid: inflight--.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise: push {data, pc_of_word, predecoded type}. The PC of each word is tracked in a small PC queue, or recomputed from the FIFO tail.
- Pre-decode uses opcode bits [6:0]:
  - 1100011 -> 2 (B)
  - 0100011 -> 1 (S)
  - 1101111 -> 3 (J)
  - all others -> 0 (I; don't-care for R/U)
- Redirect takes priority over everything else in its cycle:
  - target = redirect_base + redirect_imm (mod 2^32); bit 0 is cleared when redirect_jalr is set.
  - PC <= target.
  - FIFO is flushed.
  - drop_cnt <= inflight minus any response arriving in that same cycle; a response in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
- Pop on instr_valid && instr_ready. Push and pop in the same cycle are allowed when the FIFO is full.
- instr, instr_pc and inst_type hold stable while instr_valid && !instr_ready.

## Timing
- Reset values (asynchronous):
  - PC = RESET_PC
  - inflight = 0, drop_cnt = 0, FIFO empty
  - imem_req_valid = 0, instr_valid = 0, instr / instr_pc / inst_type = 0
  - fetch_misalign = 0
- First request is asserted in the first cycle after rst deasserts.
- Response-to-output latency: 1 cycle. A word arriving in cycle N gives instr_valid in cycle N+1; the FIFO output is registered.
- Redirect latency: the request at the target address is asserted in the cycle after redirect_valid. instr_valid is 0 from the cycle after the redirect until the new word arrives.
- With DEPTH = 2, zero-wait memory and decode always ready: one instruction per cycle sustained.
- Reset mid-flight: all state is cleared. Responses to pre-reset requests that arrive after reset are not dropped, so the memory model must be reset together with this block.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined:
  - A redirect whose target has bit 1 set (after the jalr bit-0 clear) sets fetch_misalign and halts request issue.
  - The FIFO is flushed and outstanding responses are dropped.
  - fetch_misalign clears, and fetching resumes, on the next redirect or on reset.
- Undefined: fetch_misalign port and check are absent; the target is used as computed, with bits [1:0] passed to imem_addr.

## Structure
- Shared package riscv_pkg:
  - InstType encodings I_TYPE = 0, S_TYPE = 1, B_TYPE = 2, J_TYPE = 3, identical to the immediate extender's select values
  - opcode constants OP_BRANCH, OP_STORE, OP_JAL
  - the 4-byte instruction step
- One sub-module, instr_fifo: parameterised synchronous FIFO (DEPTH, WIDTH = 66 for data + PC + type), with full/empty/count and simultaneous push/pop.

## Test plan
- Reset, RESET_PC = 0x100, zero-wait memory, decode ready -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; instr_valid from cycle 2; instr_pc matches the address.
- Decode stalls 5 cycles -> at most DEPTH fetches outstanding or buffered; instr held stable; no word lost or duplicated.
- Redirect with base 0x200, imm 0xFFFF_FFF8 while 2 fetches are in flight -> both responses dropped; next request at 0x1F8; first delivered instr_pc is 0x1F8.
- jalr redirect with base 0x301, imm 0 -> target 0x300; response in the redirect cycle discarded.
- Words 0x00000063, 0x00002023, 0x0000006F, 0x00000013 -> inst_type 2, 1, 3, 0.
- With IFETCH_MISALIGN_CHK_EN, redirect to 0x402 -> fetch_misalign = 1; imem_req_valid stays 0 until a redirect to 0x400.
